cmd_fifo_ft: RTL and testbench

- Synchronous single-clock FIFO with an optional fall-through (zero-latency) mode and occupancy reporting.
- Used as the in-order command/route queue behind stream arbiters and muxes. Example: it records which requester owns each write burst so W beats are steered in AW order.
- Generic element type via DATA_WIDTH; depth and fall-through are set by parameters.

---
 rtl/cmd_fifo_ft_pkg.sv | 6 +
 rtl/cmd_fifo_ft.sv | 61 ++++++
 tb/tb_cmd_fifo_ft.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cmd_fifo_ft_pkg.sv
// cmd_fifo_ft_pkg: sizing helper for the command FIFO pointer width
package cmd_fifo_ft_pkg;
  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/cmd_fifo_ft.sv
// cmd_fifo_ft: in-order command FIFO with optional fall-through; define CMD_FIFO_ASSERT_EN for sim checks
module cmd_fifo_ft import cmd_fifo_ft_pkg::*; #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned ADDR_DEPTH  = addr_bits(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  logic [ADDR_DEPTH-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  ft, do_push, do_pop, unused_ok;
  function automatic logic [ADDR_DEPTH-1:0] nxt(input logic [ADDR_DEPTH-1:0] p);
    return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign unused_ok = testmode_i;
  assign ft      = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign full_o  = cnt_q == (ADDR_DEPTH+1)'(DEPTH);
  assign empty_o = (cnt_q == '0) && !ft;
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign data_o  = ft ? data_i : mem_q[rptr_q];
  // a fall-through push that is popped at once never touches storage
  assign do_push = push_i && !full_o && !(ft && pop_i);
  assign do_pop  = pop_i && !empty_o && !ft;
  assign rptr_d  = flush_i ? '0 : do_pop ? nxt(rptr_q) : rptr_q;
  assign wptr_d  = flush_i ? '0 : do_push ? nxt(wptr_q) : wptr_q;
  assign cnt_d   = flush_i ? '0 : cnt_q + (ADDR_DEPTH+1)'(do_push) - (ADDR_DEPTH+1)'(do_pop);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
    end
  end
`ifdef CMD_FIFO_ASSERT_EN
  if (DEPTH == 0) begin : g_depth_err
    $error("cmd_fifo_ft: DEPTH must be at least 1");
  end
  push_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !flush_i))
    else $error("cmd_fifo_ft: push while full");
  pop_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o && !flush_i))
    else $error("cmd_fifo_ft: pop while empty");
`endif
endmodule

// File: tb/tb_cmd_fifo_ft.sv
// tb_cmd_fifo_ft: vector table, corner sequences and randomized traffic against a queue model
module tb_cmd_fifo_ft;
  logic       clk = 0, rst_n = 0;
  logic       push[3], pop[3], flush[3], full[3], empty[3];
  logic [7:0] din[3], dout[3];
  logic [1:0] usage[3];
  int         n_chk = 0, n_pass = 0;
  int         dep[3] = '{4, 4, 3};
  bit         ftm[3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] mdat[3][8];
  int         mcnt[3];
  bit         mzero[3];

  always #5 clk = ~clk;

  cmd_fifo_ft #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .testmode_i(1'b0), .full_o(full[0]),
    .empty_o(empty[0]), .usage_o(usage[0]), .data_i(din[0]), .push_i(push[0]),
    .data_o(dout[0]), .pop_i(pop[0]));
  cmd_fifo_ft #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .testmode_i(1'b0), .full_o(full[1]),
    .empty_o(empty[1]), .usage_o(usage[1]), .data_i(din[1]), .push_i(push[1]),
    .data_o(dout[1]), .pop_i(pop[1]));
  cmd_fifo_ft #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]), .testmode_i(1'b0), .full_o(full[2]),
    .empty_o(empty[2]), .usage_o(usage[2]), .data_i(din[2]), .push_i(push[2]),
    .data_o(dout[2]), .pop_i(pop[2]));

  typedef struct {
    int         k;
    bit         p, o, f;
    logic [7:0] d;
    int         u;
    bit         fu, em, cd;
    logic [7:0] dt;
  } vec_t;
  vec_t vt[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      mzero[k] = 1;
    end
  endtask

  task automatic check_model(input int k);
    bit pt;
    pt = ftm[k] && mcnt[k] == 0 && push[k];
    check($sformatf("u%0d.full", k), 32'(full[k]), 32'(mcnt[k] == dep[k]));
    check($sformatf("u%0d.empty", k), 32'(empty[k]), 32'(mcnt[k] == 0 && !pt));
    check($sformatf("u%0d.usage", k), 32'(usage[k]), 32'(mcnt[k] % 4));
    if (pt) check($sformatf("u%0d.ftdata", k), 32'(dout[k]), 32'(din[k]));
    else if (mcnt[k] > 0) check($sformatf("u%0d.head", k), 32'(dout[k]), 32'(mdat[k][0]));
    else if (mzero[k]) check($sformatf("u%0d.rstdata", k), 32'(dout[k]), 32'h0);
  endtask

  task automatic model_update(input int k);
    bit pt, dpush, dpop;
    if (flush[k]) begin
      mcnt[k] = 0;
      mzero[k] = 0;
    end else begin
      pt    = ftm[k] && mcnt[k] == 0 && push[k] && pop[k];
      dpush = push[k] && mcnt[k] < dep[k] && !pt;
      dpop  = pop[k] && mcnt[k] > 0;
      if (dpop) begin
        for (int i = 0; i < 7; i++) mdat[k][i] = mdat[k][i+1];
        mcnt[k]--;
      end
      if (dpush) begin
        mdat[k][mcnt[k]] = din[k];
        mcnt[k]++;
        mzero[k] = 0;
      end
    end
  endtask

  task automatic drive(input int k, input bit p, input bit o, input bit f, input logic [7:0] d);
    push[k] = p; pop[k] = o; flush[k] = f; din[k] = d;
    #1 check_model(k);
    @(posedge clk);
    model_update(k);
    #1 push[k] = 0; pop[k] = 0; flush[k] = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      push[k] = 0; pop[k] = 0; flush[k] = 0; din[k] = 0;
    end
    model_reset();
    vt[0]  = '{0, 1, 0, 0, 8'hA, 1, 0, 0, 1, 8'hA};
    vt[1]  = '{0, 1, 0, 0, 8'hB, 2, 0, 0, 1, 8'hA};
    vt[2]  = '{0, 1, 0, 0, 8'hC, 3, 0, 0, 1, 8'hA};
    vt[3]  = '{0, 1, 0, 0, 8'hD, 0, 1, 0, 1, 8'hA};
    vt[4]  = '{0, 1, 0, 0, 8'hE, 0, 1, 0, 1, 8'hA};
    vt[5]  = '{0, 1, 1, 0, 8'hE, 3, 0, 0, 1, 8'hB};
    vt[6]  = '{0, 0, 1, 0, 8'h0, 2, 0, 0, 1, 8'hC};
    vt[7]  = '{0, 0, 1, 0, 8'h0, 1, 0, 0, 1, 8'hD};
    vt[8]  = '{0, 0, 1, 0, 8'h0, 0, 0, 1, 0, 8'h0};
    vt[9]  = '{0, 1, 0, 0, 8'h1, 1, 0, 0, 1, 8'h1};
    vt[10] = '{0, 1, 0, 0, 8'h2, 2, 0, 0, 1, 8'h1};
    vt[11] = '{0, 1, 0, 1, 8'h3, 0, 0, 1, 0, 8'h0};
    vt[12] = '{1, 1, 0, 0, 8'h7, 1, 0, 0, 1, 8'h7};
    vt[13] = '{1, 0, 1, 0, 8'h0, 0, 0, 1, 0, 8'h0};
    vt[14] = '{2, 1, 0, 0, 8'h1, 1, 0, 0, 1, 8'h1};
    vt[15] = '{2, 1, 0, 0, 8'h2, 2, 0, 0, 1, 8'h1};
    vt[16] = '{2, 1, 0, 0, 8'h3, 3, 1, 0, 1, 8'h1};
    vt[17] = '{2, 1, 1, 0, 8'h4, 2, 0, 0, 1, 8'h2};
    vt[18] = '{2, 1, 0, 0, 8'h5, 3, 1, 0, 1, 8'h2};
    vt[19] = '{2, 1, 1, 0, 8'h6, 2, 0, 0, 1, 8'h3};
    vt[20] = '{2, 1, 1, 0, 8'h7, 2, 0, 0, 1, 8'h5};
    vt[21] = '{2, 1, 1, 0, 8'h8, 2, 0, 0, 1, 8'h7};
    vt[22] = '{2, 0, 1, 0, 8'h0, 1, 0, 0, 1, 8'h8};
    vt[23] = '{2, 0, 1, 0, 8'h0, 0, 0, 1, 0, 8'h0};
    #2;
    for (int k = 0; k < 3; k++) check_model(k);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    // fall-through: push and pop into an empty FIFO passes data straight across
    push[1] = 1; pop[1] = 1; din[1] = 8'h5;
    #1 check("ft.same_cycle_data", 32'(dout[1]), 32'h5);
    check("ft.same_cycle_empty", 32'(empty[1]), 32'h0);
    @(posedge clk);
    model_update(1);
    #1 push[1] = 0; pop[1] = 0;
    #1 check("ft.after_usage", 32'(usage[1]), 32'h0);
    check("ft.after_empty", 32'(empty[1]), 32'h1);
    for (int i = 0; i < 24; i++) begin
      drive(vt[i].k, vt[i].p, vt[i].o, vt[i].f, vt[i].d);
      #1 check($sformatf("vec%0d.usage", i), 32'(usage[vt[i].k]), 32'(vt[i].u));
      check($sformatf("vec%0d.full", i), 32'(full[vt[i].k]), 32'(vt[i].fu));
      check($sformatf("vec%0d.empty", i), 32'(empty[vt[i].k]), 32'(vt[i].em));
      if (vt[i].cd) check($sformatf("vec%0d.data", i), 32'(dout[vt[i].k]), 32'(vt[i].dt));
    end
    // async reset mid-burst with an in-flight push
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 8'h40 + 8'(i));
    push[0] = 1; din[0] = 8'h99;
    #1 rst_n = 0;
    #1 check("arst.empty", 32'(empty[0]), 32'h1);
    check("arst.data", 32'(dout[0]), 32'h0);
    check("arst.usage", 32'(usage[0]), 32'h0);
    check("arst.full", 32'(full[0]), 32'h0);
    push[0] = 0;
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 300; n++)
        drive(k, 1'($urandom % 2), 1'($urandom % 2), ($urandom % 32) == 0, 8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
